gate_sweep_checker: RTL
=======================

GATE_SWEEP_CHECKER -- requirements
Module: gate_sweep_checker

Interface
REQ-001 SHALL have parameter NUM_INPUTS, default 2: gate input count, legal 1..4.
REQ-002 SHALL have parameter EXPECTED, width 2**NUM_INPUTS, default 4'b0110: expected truth table; bit k = expected gate_out when gate_in == k.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 1: hold cycles before sampling each vector, legal 0..15.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port start, input, 1 bit: sweep request, level-sampled.
REQ-007 SHALL have port gate_in, output, NUM_INPUTS bits: vector driven to the gate under test.
REQ-008 SHALL have port gate_out, input, 1 bit: gate-under-test response, combinational from gate_in.
REQ-009 SHALL have port busy, output, 1 bit: sweep in progress.
REQ-010 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port pass, output, 1 bit: last sweep had zero mismatches.
REQ-012 SHALL have port result, output, 2**NUM_INPUTS bits: captured gate_out per vector index.
REQ-013 SHALL have port mismatch_count, output, NUM_INPUTS+1 bits: mismatching vectors in last sweep.
REQ-014 SHALL have port first_fail_idx, output, NUM_INPUTS bits: lowest mismatching index; 0 when pass.

Function
REQ-015 SHALL implement FSM states IDLE, APPLY, DONE.
REQ-016 SHALL, in IDLE or DONE with start=1 at an edge, enter APPLY with gate_in=0, busy=1, and clear result, mismatch_count, first_fail_idx, pass.
REQ-017 SHALL hold each vector SETTLE_CYCLES+1 cycles and sample gate_out at that vector's last APPLY edge.
REQ-018 SHALL, on sampling vector k, write result[k]=gate_out and increment mismatch_count if gate_out != EXPECTED[k].
REQ-019 SHALL latch first_fail_idx only on the first mismatch of a sweep.
REQ-020 SHALL increment gate_in after each sample; after sampling the last index, enter DONE.
REQ-021 SHALL, with start accepted at edge E0, assert done exactly after edge E0 + 2**NUM_INPUTS*(SETTLE_CYCLES+1), with busy=0 in that cycle.
REQ-022 SHALL set pass = (mismatch_count==0) when entering DONE; pass, result, counts hold until the next accepted start.
REQ-023 SHALL remain in DONE exactly one cycle, then go to IDLE unless start=1 (back-to-back sweep).
REQ-024 SHALL ignore start while in APPLY.
REQ-025 SHALL hold gate_in at 0 in IDLE and DONE.

Reset
REQ-026 SHALL, on rst_n=0 at any time including mid-sweep, immediately force IDLE, gate_in=0, busy=0, done=0, pass=0, result=0, mismatch_count=0, first_fail_idx=0.
REQ-027 SHALL accept no start on the first edge where rst_n is sampled high after deassertion.

Structure
REQ-028 SHALL take FSM state encoding and MAX_INPUTS=4 from shared package logic_blocks_pkg.
REQ-029 SHALL implement the per-vector hold count in one sub-module, settle_timer (load, count down, expire pulse).

Verification
REQ-030 Default params, gate_out=^gate_in, start pulsed 1 cycle -> done 8 cycles after start edge; pass=1, result=4'b0110, mismatch_count=0.
REQ-031 gate_out=&gate_in (wrong gate) -> result=4'b1000, mismatch_count=3, first_fail_idx=1, pass=0.
REQ-032 rst_n=0 during vector 2 -> all outputs 0 asynchronously; new start after release completes normally with pass=1.
REQ-033 start held high through whole sweep -> sweep not restarted mid-APPLY; second sweep begins from DONE cycle; done pulses every 9 cycles.
REQ-034 NUM_INPUTS=3, EXPECTED=8'b10010110, SETTLE_CYCLES=0, gate_out=^gate_in -> done 8 cycles after start, pass=1, result=8'b10010110.
REQ-035 gate_out stuck 0, default params -> mismatch_count=2, first_fail_idx=1, result=0.

Source files
------------

// File: rtl/logic_blocks_pkg.sv
// Shared definitions for the logic-block checkers: FSM encoding, size limits
// and a vector-count helper.
package logic_blocks_pkg;

  localparam int unsigned MAX_INPUTS = 4;
  localparam int unsigned SETTLE_W   = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_APPLY = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  // Number of exhaustive input vectors for an n-input gate, capped at MAX_INPUTS.
  function automatic int unsigned num_vectors(input int unsigned n);
    int unsigned w;
    w = (n > MAX_INPUTS) ? MAX_INPUTS : n;
    return 32'd1 << w;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Per-vector hold counter: reloads on i_load, counts down while enabled and
// pulses o_expire on the last cycle of each hold window.
module settle_timer
  import logic_blocks_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_load,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [SETTLE_W-1:0] RELOAD = SETTLE_W'(SETTLE_CYCLES);

  logic [SETTLE_W-1:0] r_count;
  logic                w_zero;

  assign w_zero   = (r_count == '0);
  assign o_expire = i_en && w_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= RELOAD;
    end else if (i_en) begin
      r_count <= w_zero ? RELOAD : (r_count - SETTLE_W'(1));
    end
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustively sweeps every input vector of a combinational gate, compares the
// response with a truth table and reports per-vector results and mismatches.
module gate_sweep_checker
  import logic_blocks_pkg::*;
#(
  parameter int unsigned NUM_INPUTS = 2,
  parameter logic [(2**NUM_INPUTS)-1:0] EXPECTED = 4'b0110,
  parameter int unsigned SETTLE_CYCLES = 1,
  localparam int unsigned NUM_VECS = num_vectors(NUM_INPUTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [NUM_INPUTS-1:0] gate_in,
  input  logic                  gate_out,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [NUM_VECS-1:0]   result,
  output logic [NUM_INPUTS:0]   mismatch_count,
  output logic [NUM_INPUTS-1:0] first_fail_idx
);

  state_t                r_state;
  logic                  r_armed;
  logic [NUM_INPUTS-1:0] r_gate_in;
  logic                  r_pass;
  logic [NUM_VECS-1:0]   r_result;
  logic [NUM_INPUTS:0]   r_mismatch_count;
  logic [NUM_INPUTS-1:0] r_first_fail_idx;

  logic                  w_accept;
  logic                  w_expire;
  logic                  w_mis;
  logic                  w_last;
  logic [NUM_INPUTS:0]   w_cnt_next;

  // r_armed blocks start on the first edge after reset release.
  assign w_accept   = r_armed && start && (r_state != ST_APPLY);
  assign w_mis      = (gate_out != EXPECTED[r_gate_in]);
  assign w_last     = (r_gate_in == '1);
  assign w_cnt_next = w_mis ? (r_mismatch_count + (NUM_INPUTS+1)'(1)) : r_mismatch_count;

  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_accept),
    .i_en    (r_state == ST_APPLY),
    .o_expire(w_expire)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= ST_IDLE;
      r_armed          <= 1'b0;
      r_gate_in        <= '0;
      r_pass           <= 1'b0;
      r_result         <= '0;
      r_mismatch_count <= '0;
      r_first_fail_idx <= '0;
    end else begin
      r_armed <= 1'b1;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_gate_in <= '0;
          if (w_accept) begin
            r_state          <= ST_APPLY;
            r_pass           <= 1'b0;
            r_result         <= '0;
            r_mismatch_count <= '0;
            r_first_fail_idx <= '0;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_APPLY: begin
          if (w_expire) begin
            r_result[r_gate_in] <= gate_out;
            r_mismatch_count    <= w_cnt_next;
            // A zero running count means this is the sweep's first mismatch.
            if (w_mis && (r_mismatch_count == '0)) begin
              r_first_fail_idx <= r_gate_in;
            end
            if (w_last) begin
              r_state   <= ST_DONE;
              r_gate_in <= '0;
              r_pass    <= (w_cnt_next == '0);
            end else begin
              r_gate_in <= r_gate_in + NUM_INPUTS'(1);
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_gate_in <= '0;
        end
      endcase
    end
  end

  assign gate_in        = r_gate_in;
  assign busy           = (r_state == ST_APPLY);
  assign done           = (r_state == ST_DONE);
  assign pass           = r_pass;
  assign result         = r_result;
  assign mismatch_count = r_mismatch_count;
  assign first_fail_idx = r_first_fail_idx;

endmodule
